// File: rtl/or_arb_pkg.sv
// ----------------------------------------------------------------------------
// or_arb_pkg
// Shared definitions for the wired-OR bus arbiter slice:
//   - arb_state_t : FSM encoding, ST_IDLE = 0, ST_BUSY = 1
//   - clog2()     : index width helper (never returns less than 1)
//   - DEF_N / DEF_W / DEF_MAX_HOLD : default requester count, bus width and
//     hold limit used by or_bus_arbiter
// ----------------------------------------------------------------------------
package or_arb_pkg;

    localparam int DEF_N        = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Width needed to index v items; clamped to 1 so single-entry
    // vectors still get a legal [0:0] range.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans requesters in the order
// ptr+1, ptr+2, ..., ptr+N (mod N) and reports the first one requesting.
// Ports:
//   req    in  [N]         request vector
//   ptr    in  [clog2(N)]  last serviced index; it is searched last
//   found  out             any request present
//   idx    out [clog2(N)]  winning index (0 when !found)
//   onehot out [N]         one-hot of idx, all zero when !found
// ----------------------------------------------------------------------------
module rr_pick
    import or_arb_pkg::*;
#(
    parameter int UUID = 0,
    parameter int N    = DEF_N
) (
    input  logic [N-1:0]        req,
    input  logic [clog2(N)-1:0] ptr,
    output logic                found,
    output logic [clog2(N)-1:0] idx,
    output logic [N-1:0]        onehot
);

    localparam int IW = clog2(N);

    if (N < 2) begin : g_bad_n
        $error("rr_pick uuid %0d: N=%0d must be at least 2", UUID, N);
    end

    int cand;

    // Walk the search order backwards so the nearest requester after ptr
    // is the last assignment and therefore wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = 0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
        if (found) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/or_bus_arbiter.sv
// ----------------------------------------------------------------------------
// or_bus_arbiter
// Round-robin owner sequencing for a shared wired-OR result bus. At most one
// requester is gated onto the OR tree, and a zero-grant turnaround cycle is
// always inserted between owners.
// Optional feature macro: OR_ARB_HOLD_LIMIT_EN -- bounds ownership to
// MAX_HOLD consecutive cycles and pulses timeout on a forced release.
// Ports:
//   clk      in             rising-edge clock
//   rst      in             synchronous reset, active high
//   req      in  [N]        per-requester request, held while using the bus
//   last     in  [N]        per-requester final-beat flag (owner's bit only)
//   data_in  in  [N*W]      requester i at [i*W +: W]
//   grant    out [N]        registered one-hot grant or zero
//   owner    out [clog2(N)] current owner index, meaningful when busy
//   busy     out            |grant
//   bus_out  out [W]        OR of granted requester data
//   timeout  out            one-cycle forced-release pulse (0 if compiled out)
// ----------------------------------------------------------------------------
module or_bus_arbiter
    import or_arb_pkg::*;
#(
    parameter int    UUID     = 0,
    parameter string NAME     = "",
    parameter int    N        = DEF_N,
    parameter int    W        = DEF_W,
    parameter int    MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        last,
    input  logic [N*W-1:0]      data_in,
    output logic [N-1:0]        grant,
    output logic [clog2(N)-1:0] owner,
    output logic                busy,
    output logic [W-1:0]        bus_out,
    output logic                timeout
);

    localparam int IW = clog2(N);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("or_bus_arbiter %s: N=%0d outside 2..8", NAME, N);
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("or_bus_arbiter %s: MAX_HOLD must be at least 1", NAME);
    end

    arb_state_t      state;
    logic [IW-1:0]   ptr;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    pick_onehot;
    logic            rel_norm;
    logic            rel_force;

    rr_pick #(
        .UUID (UUID ^ 1),
        .N    (N)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Only the owner's req/last matter while busy; everyone else waits.
    assign rel_norm = (state == ST_BUSY) && (!req[owner] || last[owner]);

`ifdef OR_ARB_HOLD_LIMIT_EN
    localparam int HW = clog2(MAX_HOLD);

    logic [HW-1:0] hold_cnt;

    assign rel_force = (state == ST_BUSY) && (hold_cnt == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            // A normal release in the limit cycle wins; no pulse then.
            timeout <= rel_force && !rel_norm;
            if (state == ST_IDLE)
                hold_cnt <= '0;
            else if (!(rel_norm || rel_force))
                hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign rel_force = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= IW'(N - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant <= pick_onehot;
                        owner <= pick_idx;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Dropping to IDLE forces the turnaround cycle; the
                    // released owner becomes ptr so it is searched last.
                    if (rel_norm || rel_force) begin
                        grant <= '0;
                        ptr   <= owner;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = |grant;

    always_comb begin
        bus_out = '0;
        for (int i = 0; i < N; i++)
            bus_out = bus_out | (data_in[i*W +: W] & {W{grant[i]}});
    end

endmodule

// File: tb/tb_or_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_or_bus_arbiter
// Directed vector table, hold-limit sequence and randomized run against a
// behavioural owner/pointer model. Build with or without
// OR_ARB_HOLD_LIMIT_EN; the bench adapts its expectations.
// ----------------------------------------------------------------------------
module tb_or_bus_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 4;
`ifdef OR_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   bus_out;
    logic           timeout;

    or_bus_arbiter #(
        .UUID     (7),
        .NAME     ("tb_arb"),
        .N        (N),
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .data_in (data_in),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .bus_out (bus_out),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: who owns the bus (-1 = nobody), who was served
    // last, and how long the current owner has held it.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    task automatic model_step();
        bit rel, frc;
        int c;
        if (rst) begin
            m_owner = -1; m_ptr = N - 1; m_hold = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int j = 1; j <= N; j++) begin
                c = (m_ptr + j) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_hold  = 0;
                    break;
                end
            end
        end else begin
            rel  = !req[m_owner] || last[m_owner];
            frc  = HOLD_EN && (m_hold == MAX_HOLD - 1);
            m_to = frc && !rel;
            if (rel || frc) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        logic [W-1:0] eb;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        eb = (m_owner < 0) ? '0 : data_in[m_owner*W +: W];
        chk({tag, " grant"},   32'(grant),   32'(eg));
        chk({tag, " busy"},    32'(busy),    32'(m_owner >= 0));
        chk({tag, " bus_out"}, 32'(bus_out), 32'(eb));
        chk({tag, " timeout"}, 32'(timeout), 32'(m_to));
        if (m_owner >= 0) chk({tag, " owner"}, 32'(owner), 32'(m_owner));
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] last;
        logic [31:0]  data;
        logic [N-1:0] g;
        logic [W-1:0] bus;
        logic         to;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic [3:0] rq, logic [3:0] ls, logic [31:0] d,
                                logic [3:0] g, logic [7:0] b);
        vec_t v;
        v = '{rst: r, req: rq, last: ls, data: d, g: g, bus: b, to: 1'b0};
        tbl.push_back(v);
    endfunction

    localparam logic [31:0] D1 = 32'h8844_22A5;
    localparam logic [31:0] D2 = 32'h883C_2211;

    initial begin
        rst = 1'b1; req = '0; last = '0; data_in = '0;
        tick(); tick();
        chk("reset grant",   32'(grant),   0);
        chk("reset busy",    32'(busy),    0);
        chk("reset owner",   32'(owner),   0);
        chk("reset bus_out", 32'(bus_out), 0);
        chk("reset timeout", 32'(timeout), 0);

        // single requester grant and release
        add(0, 4'b0001, 4'b0000, D1, 4'b0001, 8'hA5);
        add(0, 4'b0000, 4'b0000, D1, 4'b0000, 8'h00);
        // full rotation, two-beat ownerships
        add(1, 4'b0000, 4'b0000, D1, 4'b0000, 8'h00);
        add(0, 4'b1111, 4'b0000, D1, 4'b0001, 8'hA5);
        add(0, 4'b1111, 4'b0000, D1, 4'b0001, 8'hA5);
        add(0, 4'b1111, 4'b0001, D1, 4'b0000, 8'h00);
        add(0, 4'b1111, 4'b0000, D1, 4'b0010, 8'h22);
        add(0, 4'b1111, 4'b0000, D1, 4'b0010, 8'h22);
        add(0, 4'b1111, 4'b0010, D1, 4'b0000, 8'h00);
        add(0, 4'b1111, 4'b0000, D1, 4'b0100, 8'h44);
        add(0, 4'b1111, 4'b0000, D1, 4'b0100, 8'h44);
        add(0, 4'b1111, 4'b0100, D1, 4'b0000, 8'h00);
        add(0, 4'b1111, 4'b0000, D1, 4'b1000, 8'h88);
        add(0, 4'b1111, 4'b0000, D1, 4'b1000, 8'h88);
        add(0, 4'b1111, 4'b1000, D1, 4'b0000, 8'h00);
        add(0, 4'b1111, 4'b0000, D1, 4'b0001, 8'hA5);
        // owner 2 ends in grant cycle 3, next search starts at 3
        add(1, 4'b0000, 4'b0000, D2, 4'b0000, 8'h00);
        add(0, 4'b0100, 4'b0000, D2, 4'b0100, 8'h3C);
        add(0, 4'b0100, 4'b0000, D2, 4'b0100, 8'h3C);
        add(0, 4'b0100, 4'b0000, D2, 4'b0100, 8'h3C);
        add(0, 4'b0100, 4'b0100, D2, 4'b0000, 8'h00);
        add(0, 4'b1011, 4'b0000, D2, 4'b1000, 8'h88);
        // owner 1 drops as req3 rises with req0 pending: 3 beats 0
        add(1, 4'b0000, 4'b0000, D2, 4'b0000, 8'h00);
        add(0, 4'b0010, 4'b0000, D2, 4'b0010, 8'h22);
        add(0, 4'b0011, 4'b0000, D2, 4'b0010, 8'h22);
        add(0, 4'b1001, 4'b0000, D2, 4'b0000, 8'h00);
        add(0, 4'b1001, 4'b0000, D2, 4'b1000, 8'h88);
        // reset while owner 2 is busy, then fresh priority from 0
        add(1, 4'b0000, 4'b0000, D2, 4'b0000, 8'h00);
        add(0, 4'b0100, 4'b0000, D2, 4'b0100, 8'h3C);
        add(1, 4'b0100, 4'b0000, D2, 4'b0000, 8'h00);
        add(0, 4'b1111, 4'b0000, D2, 4'b0001, 8'h11);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; req = tbl[i].req; last = tbl[i].last; data_in = tbl[i].data;
            tick();
            chk($sformatf("row%0d grant", i),   32'(grant),   32'(tbl[i].g));
            chk($sformatf("row%0d bus_out", i), 32'(bus_out), 32'(tbl[i].bus));
            chk($sformatf("row%0d busy", i),    32'(busy),    32'(|tbl[i].g));
            chk($sformatf("row%0d timeout", i), 32'(timeout), 32'(tbl[i].to));
        end

        // hold-limit sequence: req0 held forever, req1 waiting
        rst = 1'b1; req = '0; last = '0; data_in = D1;
        tick();
        rst = 1'b0; req = 4'b0011;
`ifdef OR_ARB_HOLD_LIMIT_EN
        for (int k = 0; k < MAX_HOLD; k++) begin
            tick();
            chk($sformatf("hold beat%0d grant", k), 32'(grant),   32'h1);
            chk($sformatf("hold beat%0d to", k),    32'(timeout), 0);
        end
        tick();
        chk("hold release grant", 32'(grant),   0);
        chk("hold release to",    32'(timeout), 1);
        tick();
        chk("hold next grant", 32'(grant),   32'h2);
        chk("hold next to",    32'(timeout), 0);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("nohold beat%0d grant", k), 32'(grant),   32'h1);
            chk($sformatf("nohold beat%0d to", k),    32'(timeout), 0);
        end
`endif

        // randomized run against the model
        rst = 1'b1; req = '0; last = '0;
        tick();
        check_model("rnd reset");
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int b = 0; b < N; b++) begin
                req[b]  = ($urandom_range(0, 3) != 0);
                last[b] = ($urandom_range(0, 7) == 0);
            end
            data_in = $urandom;
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
